// File: rtl/traffic_lane_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : traffic_lane_ctrl
// Purpose  : Runtime-programmable car lane engine with a one-car-per-cycle
//            movement sweep, modulo wrap and player collision detection.
// Revision : 1.0
// ============================================================================
module traffic_lane_ctrl #(
   parameter int NUM_CARS      = 10,
   parameter int POS_W         = 6,
   parameter int c_MAX_X       = 20,
   parameter int c_BASE_TICKS  = 2000000,
   parameter int c_LEVEL_STEP  = 150000,
   parameter int c_MIN_TICKS   = 400000,
   parameter int COUNTER_WIDTH = 26
) (
   input  logic                      i_Clk,
   input  logic                      i_Rst_n,
   input  logic                      i_Pause,
   input  logic [3:0]                i_Level,
   input  logic [POS_W-1:0]          i_Player_X,
   input  logic [POS_W-1:0]          i_Player_Y,
   input  logic                      i_Cfg_Valid,
   output logic                      o_Cfg_Ready,
   input  logic [4:0]                i_Cfg_Idx,
   input  logic [POS_W-1:0]          i_Cfg_X,
   input  logic [POS_W-1:0]          i_Cfg_Y,
   input  logic [POS_W-1:0]          i_Cfg_Speed,
   input  logic                      i_Cfg_Dir,
   output logic [NUM_CARS*POS_W-1:0] o_Car_X,
   output logic [NUM_CARS*POS_W-1:0] o_Car_Y,
   output logic                      o_Busy,
   output logic                      o_Sweep_Done,
   output logic                      o_Hit,
   output logic [4:0]                o_Hit_Idx
);

   localparam int c_PW    = COUNTER_WIDTH + 4;
   localparam int c_IDX_W = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;

   localparam logic [c_PW-1:0]    c_BASE_P   = c_PW'(c_BASE_TICKS);
   localparam logic [c_PW-1:0]    c_STEP_P   = c_PW'(c_LEVEL_STEP);
   localparam logic [c_PW-1:0]    c_MIN_P    = c_PW'(c_MIN_TICKS);
   localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_CARS - 1);
   localparam logic [POS_W-1:0]   c_MAX_XV   = POS_W'(c_MAX_X);
   localparam logic [POS_W:0]     c_SPAN     = (POS_W+1)'(c_MAX_X + 1);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_SWEEP  = 2'd1,
      ST_PAUSED = 2'd2
   } state_t;

   state_t r_state, w_state_nxt;

   logic [POS_W-1:0]         r_x   [NUM_CARS];
   logic [POS_W-1:0]         r_y   [NUM_CARS];
   logic [POS_W-1:0]         r_spd [NUM_CARS];
   logic [NUM_CARS-1:0]      r_dir;
   logic [COUNTER_WIDTH-1:0] r_count;
   logic [c_IDX_W-1:0]       r_idx;
   logic                     r_hit_flag;
   logic [4:0]               r_hit_idx;
   logic                     r_sweep_done;
   logic                     r_hit;

   logic [c_PW-1:0]  w_reduction, w_period, w_count_ext;
   logic             w_tick, w_sweep_end, w_cfg_fire, w_match;
   logic [POS_W-1:0] w_cur_x, w_cur_spd, w_new_x, w_cfg_x, w_cfg_spd;
   logic             w_cur_dir;
   logic [POS_W:0]   w_sum;

   // The period floor is taken before the subtraction can go negative.
   assign w_reduction = c_PW'(i_Level) * c_STEP_P;
   assign w_period    = (c_BASE_P > (w_reduction + c_MIN_P)) ? (c_BASE_P - w_reduction) : c_MIN_P;
   assign w_count_ext = c_PW'(r_count);
   assign w_tick      = (r_state != ST_PAUSED) && (w_count_ext >= (w_period - c_PW'(1)));

   assign w_sweep_end = (r_state == ST_SWEEP) && (r_idx == c_LAST_IDX);
   assign o_Cfg_Ready = (r_state != ST_SWEEP);
   assign w_cfg_fire  = i_Cfg_Valid && o_Cfg_Ready;
   assign w_cfg_x     = (i_Cfg_X > c_MAX_XV) ? c_MAX_XV : i_Cfg_X;
   assign w_cfg_spd   = (i_Cfg_Speed > c_MAX_XV) ? c_MAX_XV : i_Cfg_Speed;

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cur_x     = r_x[r_idx];
      w_cur_spd   = r_spd[r_idx];
      w_cur_dir   = r_dir[r_idx];
      w_sum       = {1'b0, w_cur_x} + {1'b0, w_cur_spd};
      w_new_x     = w_cur_x;
      if (w_cur_spd != '0) begin
         if (w_cur_dir) begin
            w_new_x = (w_sum > {1'b0, c_MAX_XV}) ? POS_W'(w_sum - c_SPAN) : w_sum[POS_W-1:0];
         end else begin
            w_new_x = (w_cur_x >= w_cur_spd) ? (w_cur_x - w_cur_spd)
                    : POS_W'({1'b0, w_cur_x} + c_SPAN - {1'b0, w_cur_spd});
         end
      end
      w_match = (w_new_x == i_Player_X) && (r_y[r_idx] == i_Player_Y);

      case (r_state)
         ST_RUN: begin
            if (w_tick) begin
               w_state_nxt = ST_SWEEP;
            end else if (i_Pause) begin
               w_state_nxt = ST_PAUSED;
            end
         end
         ST_SWEEP: begin
            if (w_sweep_end) begin
               w_state_nxt = i_Pause ? ST_PAUSED : ST_RUN;
            end
         end
         ST_PAUSED: begin
            if (!i_Pause) begin
               w_state_nxt = ST_RUN;
            end
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_count <= '0;
      end else if (r_state != ST_PAUSED) begin
         r_count <= w_tick ? '0 : (r_count + COUNTER_WIDTH'(1));
      end
   end

   // Config writes and sweep updates never coincide: the port is closed in SWEEP.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         for (int i = 0; i < NUM_CARS; i++) begin
            r_x[i]   <= '0;
            r_y[i]   <= POS_W'(i);
            r_spd[i] <= POS_W'(1);
            r_dir[i] <= 1'b1;
         end
      end else begin
         for (int i = 0; i < NUM_CARS; i++) begin
            if (w_cfg_fire && (i_Cfg_Idx == 5'(i))) begin
               r_x[i]   <= w_cfg_x;
               r_y[i]   <= i_Cfg_Y;
               r_spd[i] <= w_cfg_spd;
               r_dir[i] <= i_Cfg_Dir;
            end else if ((r_state == ST_SWEEP) && (r_idx == c_IDX_W'(i))) begin
               r_x[i] <= w_new_x;
            end
         end
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_idx        <= '0;
         r_hit_flag   <= 1'b0;
         r_hit_idx    <= '0;
         r_sweep_done <= 1'b0;
         r_hit        <= 1'b0;
      end else begin
         r_sweep_done <= w_sweep_end;
         r_hit        <= w_sweep_end && (r_hit_flag || w_match);
         if ((r_state == ST_RUN) && w_tick) begin
            r_idx      <= '0;
            r_hit_flag <= 1'b0;
         end else if (r_state == ST_SWEEP) begin
            if (!w_sweep_end) begin
               r_idx <= r_idx + c_IDX_W'(1);
            end
            if (w_match && !r_hit_flag) begin
               r_hit_flag <= 1'b1;
               r_hit_idx  <= 5'(r_idx);
            end
         end
      end
   end

   assign o_Busy       = (r_state == ST_SWEEP);
   assign o_Sweep_Done = r_sweep_done;
   assign o_Hit        = r_hit;
   assign o_Hit_Idx    = r_hit_idx;

   for (genvar gi = 0; gi < NUM_CARS; gi++) begin : g_car_out
      assign o_Car_X[gi*POS_W +: POS_W] = r_x[gi];
      assign o_Car_Y[gi*POS_W +: POS_W] = r_y[gi];
   end

endmodule
`default_nettype wire

// File: tb/tb_traffic_lane_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_lane_ctrl
// Purpose  : Directed and randomized checks of traffic_lane_ctrl against a
//            behavioural lane model.
// Revision : 1.0
// ============================================================================
module tb_traffic_lane_ctrl;
   localparam int NC   = 4;
   localparam int PW   = 6;
   localparam int MAXX = 20;
   localparam int BASE = 40;
   localparam int STEP = 2;
   localparam int MINT = 20;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          pause = 1'b0;
   logic [3:0]    level = '0;
   logic [PW-1:0] px = 6'd63, py = 6'd63;
   logic          cfg_valid = 1'b0;
   logic          cfg_ready;
   logic [4:0]    cfg_idx = '0;
   logic [PW-1:0] cfg_x = '0, cfg_y = '0, cfg_spd = '0;
   logic          cfg_dir = 1'b0;
   logic [NC*PW-1:0] car_x, car_y;
   logic          busy, done, hit;
   logic [4:0]    hit_idx;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   traffic_lane_ctrl #(
      .NUM_CARS(NC), .POS_W(PW), .c_MAX_X(MAXX), .c_BASE_TICKS(BASE),
      .c_LEVEL_STEP(STEP), .c_MIN_TICKS(MINT), .COUNTER_WIDTH(26)
   ) dut (
      .i_Clk(clk), .i_Rst_n(rst_n), .i_Pause(pause), .i_Level(level),
      .i_Player_X(px), .i_Player_Y(py),
      .i_Cfg_Valid(cfg_valid), .o_Cfg_Ready(cfg_ready), .i_Cfg_Idx(cfg_idx),
      .i_Cfg_X(cfg_x), .i_Cfg_Y(cfg_y), .i_Cfg_Speed(cfg_spd), .i_Cfg_Dir(cfg_dir),
      .o_Car_X(car_x), .o_Car_Y(car_y), .o_Busy(busy), .o_Sweep_Done(done),
      .o_Hit(hit), .o_Hit_Idx(hit_idx)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_x[NC], m_y[NC], m_s[NC], m_d[NC];
   int m_cnt, m_k, m_hidx, m_hidx_out;
   bit m_sweep, m_paused, m_done, m_hit;

   function automatic int period(input int lvl);
      int p = BASE - lvl * STEP;
      return (p > MINT) ? p : MINT;
   endfunction

   function automatic int move(input int x, input int s, input int d);
      if (d != 0) return (x + s) % (MAXX + 1);
      return (x - s + MAXX + 1) % (MAXX + 1);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NC; i++) begin
         m_x[i] = 0; m_y[i] = i; m_s[i] = 1; m_d[i] = 1;
      end
      m_cnt = 0; m_k = 0; m_hidx = -1; m_hidx_out = 0;
      m_sweep = 0; m_paused = 0; m_done = 0; m_hit = 0;
   endtask

   task automatic model_step();
      bit tick;
      bit was_paused;
      int nx;
      was_paused = m_paused;
      tick = !m_paused && (m_cnt >= period(int'(level)) - 1);
      m_done = 0;
      m_hit  = 0;
      if (cfg_valid && !m_sweep && int'(cfg_idx) < NC) begin
         m_x[cfg_idx] = (int'(cfg_x) > MAXX) ? MAXX : int'(cfg_x);
         m_y[cfg_idx] = int'(cfg_y);
         m_s[cfg_idx] = (int'(cfg_spd) > MAXX) ? MAXX : int'(cfg_spd);
         m_d[cfg_idx] = int'(cfg_dir);
      end
      if (m_sweep) begin
         nx = move(m_x[m_k], m_s[m_k], m_d[m_k]);
         m_x[m_k] = nx;
         if (nx == int'(px) && m_y[m_k] == int'(py) && m_hidx < 0) m_hidx = m_k;
         if (m_k == NC - 1) begin
            m_done = 1;
            m_hit = (m_hidx >= 0);
            if (m_hit) m_hidx_out = m_hidx;
            m_sweep = 0;
            m_paused = pause;
         end else begin
            m_k++;
         end
      end else if (m_paused) begin
         if (!pause) m_paused = 0;
      end else if (tick) begin
         m_sweep = 1; m_k = 0; m_hidx = -1;
      end else if (pause) begin
         m_paused = 1;
      end
      if (!was_paused) m_cnt = tick ? 0 : m_cnt + 1;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else model_step();
   end

   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < NC; i++) begin
            chk($sformatf("car_x[%0d]", i), int'(car_x[i*PW +: PW]), m_x[i]);
            chk($sformatf("car_y[%0d]", i), int'(car_y[i*PW +: PW]), m_y[i]);
         end
         chk("busy", int'(busy), int'(m_sweep));
         chk("cfg_ready", int'(cfg_ready), int'(!m_sweep));
         chk("sweep_done", int'(done), int'(m_done));
         chk("hit", int'(hit), int'(m_hit));
         if (m_hit) chk("hit_idx", int'(hit_idx), m_hidx_out);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_done();
      bit ok = 0;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (done) begin ok = 1; break; end
      end
      if (!ok) chk("wait_done_timeout", 0, 1);
   endtask

   task automatic wait_busy();
      bit ok = 0;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (busy) begin ok = 1; break; end
      end
      if (!ok) chk("wait_busy_timeout", 0, 1);
   endtask

   task automatic cfg(input int idx, input int x, input int y, input int s, input int d);
      bit ok = 0;
      @(posedge clk); #1;
      cfg_idx = 5'(idx); cfg_x = PW'(x); cfg_y = PW'(y); cfg_spd = PW'(s); cfg_dir = d[0];
      cfg_valid = 1'b1;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (cfg_ready) begin
            @(posedge clk); #1;
            cfg_valid = 1'b0;
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         cfg_valid = 1'b0;
         chk("cfg_timeout", 0, 1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      bit xfer;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      // Reset values.
      @(negedge clk);
      for (int i = 0; i < NC; i++) begin
         chk("rst_x", int'(car_x[i*PW +: PW]), 0);
         chk("rst_y", int'(car_y[i*PW +: PW]), i);
      end
      chk("rst_busy", int'(busy), 0);
      chk("rst_ready", int'(cfg_ready), 1);
      chk("rst_hit_idx", int'(hit_idx), 0);

      // First sweep moves every car one cell right.
      wait_done();
      for (int i = 0; i < NC; i++) chk("first_sweep_x", int'(car_x[i*PW +: PW]), 1);

      // Wrap in both directions.
      cfg(0, 19, 0, 3, 1);
      cfg(1, 1, 1, 3, 0);
      wait_done();
      chk("wrap_right", int'(car_x[0 +: PW]), 1);
      chk("wrap_left", int'(car_x[PW +: PW]), 19);

      // Two cars land on the player; the lower index is reported.
      @(posedge clk); #1;
      px = 6'd5; py = 6'd2;
      cfg(2, 4, 2, 1, 1);
      cfg(3, 3, 2, 2, 1);
      wait_done();
      chk("collide_hit", int'(hit), 1);
      chk("collide_idx", int'(hit_idx), 2);
      @(posedge clk); #1;
      px = 6'd63; py = 6'd63;

      // Pause requested mid-sweep: sweep completes, then everything freezes.
      wait_busy();
      @(posedge clk); #1;
      pause = 1'b1;
      wait_done();
      repeat (200) @(negedge clk);
      chk("pause_x0", int'(car_x[0 +: PW]), 7);
      chk("pause_x1", int'(car_x[PW +: PW]), 13);
      chk("pause_x2", int'(car_x[2*PW +: PW]), 6);
      chk("pause_x3", int'(car_x[3*PW +: PW]), 7);
      chk("pause_busy", int'(busy), 0);
      @(posedge clk); #1;
      pause = 1'b0;
      n = 0;
      for (int t = 1; t <= 100; t++) begin
         @(posedge clk); #1;
         if (busy) begin n = t; break; end
      end
      chk("resume_latency", n, 37);

      // Backpressure while sweeping, clamping, out-of-range index.
      cfg_idx = 5'd0; cfg_x = 6'd30; cfg_y = 6'd0; cfg_spd = 6'd40; cfg_dir = 1'b1;
      cfg_valid = 1'b1;
      chk("ready_in_sweep", int'(cfg_ready), 0);
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (cfg_ready) break;
      end
      chk("ready_with_done", int'(done), 1);
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      @(negedge clk);
      chk("clamp_x", int'(car_x[0 +: PW]), 20);
      cfg(31, 9, 9, 9, 0);
      @(negedge clk);
      chk("idx31_no_change", int'(car_x[0 +: PW]), 20);
      wait_done();
      chk("clamp_speed", int'(car_x[0 +: PW]), 19);

      // Highest level hits the period floor.
      @(posedge clk); #1;
      level = 4'd15;
      wait_done();
      n = 0;
      for (int t = 1; t <= 200; t++) begin
         @(negedge clk);
         if (done) begin n = t; break; end
      end
      chk("level15_period", n, MINT);

      // Asynchronous reset mid-sweep.
      wait_busy();
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_done", int'(done), 0);
      chk("async_rst_x0", int'(car_x[0 +: PW]), 0);
      chk("async_rst_ready", int'(cfg_ready), 1);
      @(negedge clk);
      #2 rst_n = 1'b1;

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         xfer = cfg_valid && cfg_ready;
         @(posedge clk); #1;
         if (!cfg_valid || xfer) begin
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_idx   = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 4));
            cfg_x     = PW'($urandom_range(0, 63));
            cfg_y     = PW'($urandom_range(0, 3));
            cfg_spd   = PW'($urandom_range(0, 63));
            cfg_dir   = 1'($urandom_range(0, 1));
         end
         if ($urandom_range(0, 60) == 0) pause = ~pause;
         if ($urandom_range(0, 200) == 0) level = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 9) == 0) begin
            px = PW'($urandom_range(0, MAXX));
            py = PW'($urandom_range(0, 3));
         end
      end
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      pause = 1'b0;
      repeat (5) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/traffic_lane_ctrl.md
# traffic_lane_ctrl

- Parametrised traffic engine for the game playfield; generation after the fixed ten-car mover.
- Holds position, speed and direction for `NUM_CARS` cars in registers, programmable at runtime through a valid/ready config port.
- Advances all cars in a one-car-per-cycle sweep on each level-scaled movement tick, with exact modulo wrap.
- Flags a collision with the player cell at the end of each sweep; feeds the renderer and the game-state FSM.

## Interface
- `NUM_CARS`, 10, number of cars (1..32)
- `POS_W`, 6, bit width of X, Y and speed fields
- `c_MAX_X`, 20, highest legal X; the lane spans 0..c_MAX_X
- `c_BASE_TICKS`, 2000000, tick period in clocks at level 0
- `c_LEVEL_STEP`, 150000, period reduction per level
- `c_MIN_TICKS`, 400000, period floor; must exceed NUM_CARS+2
- `COUNTER_WIDTH`, 26, tick counter width
- `i_Clk`  in  1  system clock
- `i_Rst_n`  in  1  reset, asynchronous, active-low
- `i_Pause`  in  1  level-sensitive pause request
- `i_Level`  in  4  difficulty level 0..15
- `i_Player_X`, `i_Player_Y`  in  POS_W each  player cell
- `i_Cfg_Valid`  in  1  config request
- `o_Cfg_Ready`  out  1  config accept
- `i_Cfg_Idx`  in  5  target car index
- `i_Cfg_X`, `i_Cfg_Y`, `i_Cfg_Speed`  in  POS_W each  new car state
- `i_Cfg_Dir`  in  1  1 = right, 0 = left
- `o_Car_X`, `o_Car_Y`  out  NUM_CARS*POS_W  flattened positions; car i at [i*POS_W +: POS_W]
- `o_Busy`  out  1  sweep in progress
- `o_Sweep_Done`  out  1  one-cycle pulse at the end of each sweep
- `o_Hit`  out  1  one-cycle pulse, coincident with `o_Sweep_Done`, when any car occupies the player cell
- `o_Hit_Idx`  out  5  lowest colliding index; valid while `o_Hit` = 1

## Operation
- **Reset values:** car i has X=0, Y=i, speed=1, dir=1. Counter=0. State=RUN. `o_Busy`, `o_Sweep_Done`, `o_Hit` and `o_Hit_Idx` are all 0. `o_Cfg_Ready`=1.
- **Tick period:** `P = max(c_BASE_TICKS - i_Level*c_LEVEL_STEP, c_MIN_TICKS)`, computed combinationally at COUNTER_WIDTH+4 bits.
- **Tick generation:** the counter increments in RUN and SWEEP; it holds in PAUSED. When counter >= P-1, the counter goes to 0 and a tick is raised. A level change therefore takes effect mid-period without a stall.
- **FSM states:**
  - RUN: a tick moves to SWEEP with idx=0 and the hit flag cleared. Otherwise `i_Pause`=1 moves to PAUSED.
  - SWEEP: updates car idx, then increments idx. After car NUM_CARS-1 it pulses `o_Sweep_Done` (and `o_Hit` if flagged) and returns to RUN, or to PAUSED if `i_Pause`=1.
  - PAUSED: `i_Pause`=0 returns to RUN. Ticks are never generated while paused.
- **Pause during a sweep:** the sweep always completes; it is never aborted.
- **Move right:** `s = X + speed` at POS_W+1 bits. If `s > c_MAX_X`, new X = `s - (c_MAX_X+1)`; otherwise new X = s.
- **Move left:** if `X >= speed`, new X = `X - speed`; otherwise new X = `X + (c_MAX_X+1) - speed`.
- **Speed 0:** the car is parked; X is unchanged.
- **Collision check:** uses the updated X and Y of car idx against `i_Player_*`, sampled that cycle. The first match latches `o_Hit_Idx`; later matches are ignored.
- **Config port:**
  - `o_Cfg_Ready` = 0 in SWEEP, 1 otherwise.
  - A transfer occurs on `i_Cfg_Valid & o_Cfg_Ready`. Fields are written on that edge and are visible on outputs the next cycle.
  - X is clamped to c_MAX_X and speed is clamped to c_MAX_X. Y is stored as given.
  - `i_Cfg_Idx >= NUM_CARS`: the transfer is accepted and discarded.
  - A requester holds its request until accepted.
- **Write vs. tick:** if a config write and a tick occur on the same edge, the write lands and the sweep starts next cycle, using the new values.

## Timing
- Tick to first car update: 1 cycle (SWEEP entry), then one car per cycle.
- Sweep length: NUM_CARS cycles. `o_Busy`=1 throughout the sweep.
- `o_Sweep_Done`/`o_Hit`: asserted in the cycle after the last car update, for one cycle.
- Outputs are registered, so each car's output changes one cycle after its update slot.
- Mid-operation reset: all state returns to the reset values immediately (asynchronous). No pulse output glitches high on reset release.

## Test plan
- Reset, with c_BASE_TICKS=40, c_MIN_TICKS=20, NUM_CARS=4 -> X=0,0,0,0 and Y=0,1,2,3; after a 40-cycle tick and a 4-cycle sweep, all X=1 and `o_Sweep_Done` pulses once.
- Wrap: car 0 configured X=19, speed 3, dir 1, c_MAX_X=20 -> X=1. Car 1 configured X=1, speed 3, dir 0 -> X=19.
- Collision: player (5,2), car 2 configured X=4, Y=2, speed 1, dir 1; car 3 also lands on (5,2) -> `o_Hit`=1 and `o_Hit_Idx`=2 together with `o_Sweep_Done`.
- Pause: `i_Pause` asserted mid-sweep -> the sweep finishes, then no position change for 200 cycles; release -> counter resumes from its held value.
- Config backpressure: `i_Cfg_Valid` raised during SWEEP -> `o_Cfg_Ready`=0 until the sweep ends, accepted the cycle after; idx=31 is accepted with no car changed; speed 40 is stored as 20.
- Level: `i_Level`=15 -> tick period equals c_MIN_TICKS; asserting `i_Rst_n`=0 mid-sweep clears `o_Busy` immediately.
